// File: rtl/pio_pkg.sv
// Shared definitions for the PIO shift engine: shift directions, count
// decoding and command priority.
package pio_pkg;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  // Wide enough to hold a decoded count for the largest supported DW (64).
  localparam int CNT_W = 7;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_LOAD,
    CMD_PUSH,
    CMD_PULL,
    CMD_IN,
    CMD_OUT
  } cmd_e;

  function automatic logic [CNT_W-1:0] cnt_decode(input logic [CNT_W-1:0] n,
                                                  input logic [CNT_W-1:0] dw);
    return (n == '0) ? dw : n;
  endfunction

  function automatic cmd_e cmd_select(input logic load, input logic push,
                                      input logic pull, input logic in_c,
                                      input logic out_c);
    if (load) return CMD_LOAD;
    if (push) return CMD_PUSH;
    if (pull) return CMD_PULL;
    if (in_c) return CMD_IN;
    if (out_c) return CMD_OUT;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/pio_funnel.sv
// Combinational shift/merge stage: shifts a register by n (1..DW) bits in
// either direction, merging fill bits in and returning the bits shifted out.
module pio_funnel
  import pio_pkg::*;
#(
  parameter int DW = 32,
  parameter int NW = $clog2(DW)
) (
  input  logic          dir,
  input  logic [NW:0]   n,
  input  logic [DW-1:0] reg_in,
  input  logic [DW-1:0] fill_data,
  output logic [DW-1:0] new_reg,
  output logic [DW-1:0] shifted_out
);

  localparam int CW = NW + 1;
  localparam logic [CW-1:0] DW_C = CW'(DW);

  logic [DW-1:0]   mask;
  logic [DW-1:0]   fill_m;
  logic [2*DW-1:0] wide;

  // The double-width shift yields both halves of a left shift at once and
  // stays well defined when n equals DW.
  always_comb begin
    mask        = {DW{1'b1}} >> (DW_C - n);
    fill_m      = fill_data & mask;
    wide        = '0;
    new_reg     = reg_in;
    shifted_out = '0;
    case (dir)
      SHIFT_LEFT: begin
        wide        = {{DW{1'b0}}, reg_in} << n;
        new_reg     = wide[DW-1:0] | fill_m;
        shifted_out = wide[2*DW-1:DW];
      end
      SHIFT_RIGHT: begin
        new_reg     = (reg_in >> n) | (fill_m << (DW_C - n));
        shifted_out = reg_in & mask;
      end
    endcase
  end

endmodule

// File: rtl/pio_shift_unit.sv
// PIO shift engine: holds ISR/OSR, executes IN/OUT/PUSH/PULL/MOV commands and
// handles autopush/autopull thresholds with stall and FIFO handshakes.
module pio_shift_unit
  import pio_pkg::*;
#(
  parameter int DW = 32,
  parameter int NW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          penable,
  input  logic          in_dir,
  input  logic          out_dir,
  input  logic          auto_push,
  input  logic          auto_pull,
  input  logic [NW-1:0] isr_thresh,
  input  logic [NW-1:0] osr_thresh,
  input  logic          do_in,
  input  logic [NW-1:0] in_count,
  input  logic [DW-1:0] in_data,
  input  logic          do_out,
  input  logic [NW-1:0] out_count,
  output logic [DW-1:0] out_data,
  input  logic          do_push,
  input  logic          do_pull,
  input  logic          if_flag,
  input  logic          block,
  input  logic [DW-1:0] x_in,
  input  logic          load_isr,
  input  logic          load_osr,
  input  logic [DW-1:0] load_val,
  output logic          stall,
  output logic          rx_push,
  output logic [DW-1:0] rx_data,
  input  logic          rx_full,
  output logic          tx_pull,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_empty,
  output logic          rx_overflow,
  output logic [NW:0]   isr_count,
  output logic [NW:0]   osr_count
);

  localparam int CW = NW + 1;
  localparam int SW = NW + 2;
  localparam logic [CW-1:0] DW_C = CW'(DW);

  logic [DW-1:0] isr_q, isr_d;
  logic [DW-1:0] osr_q, osr_d;
  logic [CW-1:0] isr_count_q, isr_count_d;
  logic [CW-1:0] osr_count_q, osr_count_d;

  logic [CW-1:0] n_in, n_out, isr_t, osr_t;
  logic [SW-1:0] in_sum, out_sum;
  logic [DW-1:0] isr_shifted, osr_shifted, osr_spill, isr_out_unused;
  logic          rx_push_c, tx_pull_c, rx_overflow_c, strobe_en;
  cmd_e          cmd;

  assign n_in  = CW'(cnt_decode(CNT_W'(in_count), CNT_W'(DW)));
  assign n_out = CW'(cnt_decode(CNT_W'(out_count), CNT_W'(DW)));
  assign isr_t = CW'(cnt_decode(CNT_W'(isr_thresh), CNT_W'(DW)));
  assign osr_t = CW'(cnt_decode(CNT_W'(osr_thresh), CNT_W'(DW)));

  assign in_sum  = SW'(isr_count_q) + SW'(n_in);
  assign out_sum = SW'(osr_count_q) + SW'(n_out);

  assign cmd = cmd_select(load_isr | load_osr, do_push, do_pull, do_in, do_out);

  pio_funnel #(.DW(DW), .NW(NW)) u_isr_funnel (
    .dir         (in_dir),
    .n           (n_in),
    .reg_in      (isr_q),
    .fill_data   (in_data),
    .new_reg     (isr_shifted),
    .shifted_out (isr_out_unused)
  );

  pio_funnel #(.DW(DW), .NW(NW)) u_osr_funnel (
    .dir         (out_dir),
    .n           (n_out),
    .reg_in      (osr_q),
    .fill_data   ('0),
    .new_reg     (osr_shifted),
    .shifted_out (osr_spill)
  );

  always_comb begin
    isr_d         = isr_q;
    osr_d         = osr_q;
    isr_count_d   = isr_count_q;
    osr_count_d   = osr_count_q;
    stall         = 1'b0;
    rx_push_c     = 1'b0;
    tx_pull_c     = 1'b0;
    rx_overflow_c = 1'b0;
    rx_data       = '0;
    out_data      = '0;
    unique case (cmd)
      CMD_LOAD: begin
        if (load_isr) begin
          isr_d       = load_val;
          isr_count_d = '0;
        end
        if (load_osr) begin
          osr_d       = load_val;
          osr_count_d = '0;
        end
      end
      CMD_PUSH: begin
        if (!(if_flag && (isr_count_q < isr_t))) begin
          if (rx_full && block) begin
            stall = 1'b1;
          end else begin
            rx_overflow_c = rx_full;
            rx_push_c     = !rx_full;
            rx_data       = isr_q;
            isr_d         = '0;
            isr_count_d   = '0;
          end
        end
      end
      CMD_PULL: begin
        if (!(if_flag && (osr_count_q < osr_t))) begin
          if (tx_empty && block) begin
            stall = 1'b1;
          end else begin
            tx_pull_c   = !tx_empty;
            osr_d       = tx_empty ? x_in : tx_data;
            osr_count_d = '0;
          end
        end
      end
      CMD_IN: begin
        if (auto_push && (in_sum >= SW'(isr_t))) begin
          if (rx_full) begin
            stall = 1'b1;
          end else begin
            rx_push_c   = 1'b1;
            rx_data     = isr_shifted;
            isr_d       = '0;
            isr_count_d = '0;
          end
        end else begin
          isr_d       = isr_shifted;
          isr_count_d = (in_sum > SW'(DW_C)) ? DW_C : CW'(in_sum);
        end
      end
      CMD_OUT: begin
        // An exhausted OSR spends this tick refilling; the shift itself is
        // retried on the next tick, so the refill still reports stall.
        if (auto_pull && (osr_count_q >= osr_t)) begin
          stall = 1'b1;
          if (!tx_empty) begin
            tx_pull_c   = 1'b1;
            osr_d       = tx_data;
            osr_count_d = '0;
          end
        end else begin
          out_data    = osr_spill;
          osr_d       = osr_shifted;
          osr_count_d = (out_sum > SW'(DW_C)) ? DW_C : CW'(out_sum);
        end
      end
      default: ;
    endcase
  end

  assign strobe_en   = penable & reset;
  assign rx_push     = rx_push_c & strobe_en;
  assign tx_pull     = tx_pull_c & strobe_en;
  assign rx_overflow = rx_overflow_c & strobe_en;
  assign isr_count   = isr_count_q;
  assign osr_count   = osr_count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      isr_q       <= '0;
      osr_q       <= '0;
      isr_count_q <= '0;
      osr_count_q <= DW_C;
    end else if (penable) begin
      isr_q       <= isr_d;
      osr_q       <= osr_d;
      isr_count_q <= isr_count_d;
      osr_count_q <= osr_count_d;
    end
  end

endmodule

// File: tb/tb_pio_shift_unit.sv
// Self-checking bench for pio_shift_unit: directed scenarios plus randomized
// commands checked against an arithmetic reference model.
module tb_pio_shift_unit;

  logic        clk = 1'b0;
  logic        reset, penable, in_dir, out_dir, auto_push, auto_pull;
  logic [4:0]  isr_thresh, osr_thresh, in_count, out_count;
  logic [31:0] in_data, out_data, x_in, load_val, rx_data, tx_data;
  logic        do_in, do_out, do_push, do_pull, if_flag, block;
  logic        load_isr, load_osr, stall, rx_push, rx_full, tx_pull, tx_empty;
  logic        rx_overflow;
  logic [5:0]  isr_count, osr_count;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_isr, m_osr, nx_isr, nx_osr, e_rx, e_out;
  int          m_ic, m_oc, nx_ic, nx_oc;
  logic        e_stall, e_push, e_pull, e_ovf, e_out_v;

  always #5 clk = ~clk;

  pio_shift_unit #(.DW(32)) dut (
    .clk(clk), .reset(reset), .penable(penable), .in_dir(in_dir),
    .out_dir(out_dir), .auto_push(auto_push), .auto_pull(auto_pull),
    .isr_thresh(isr_thresh), .osr_thresh(osr_thresh), .do_in(do_in),
    .in_count(in_count), .in_data(in_data), .do_out(do_out),
    .out_count(out_count), .out_data(out_data), .do_push(do_push),
    .do_pull(do_pull), .if_flag(if_flag), .block(block), .x_in(x_in),
    .load_isr(load_isr), .load_osr(load_osr), .load_val(load_val),
    .stall(stall), .rx_push(rx_push), .rx_data(rx_data), .rx_full(rx_full),
    .tx_pull(tx_pull), .tx_data(tx_data), .tx_empty(tx_empty),
    .rx_overflow(rx_overflow), .isr_count(isr_count), .osr_count(osr_count)
  );

  function automatic int dec(int v);
    return (v == 0) ? 32 : v;
  endfunction

  function automatic longint unsigned p2(int n);
    return 64'd1 << n;
  endfunction

  task automatic clear_cmd();
    do_in = 0; do_out = 0; do_push = 0; do_pull = 0;
    load_isr = 0; load_osr = 0; if_flag = 0; block = 0;
  endtask

  task automatic defaults();
    clear_cmd();
    penable = 1; in_dir = 0; out_dir = 0; auto_push = 0; auto_pull = 0;
    isr_thresh = 0; osr_thresh = 0; in_count = 0; out_count = 0;
    in_data = 0; x_in = 0; load_val = 0; tx_data = 0;
    rx_full = 0; tx_empty = 1;
  endtask

  task automatic do_reset();
    defaults();
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
  endtask

  // Reference model: expected outputs and next state from the command rules.
  task automatic model_eval();
    int n, t;
    longint unsigned lo, v;
    e_stall = 0; e_push = 0; e_pull = 0; e_ovf = 0; e_out_v = 0;
    e_rx = 0; e_out = 0;
    nx_isr = m_isr; nx_osr = m_osr; nx_ic = m_ic; nx_oc = m_oc;
    if (load_isr || load_osr) begin
      if (load_isr) begin nx_isr = load_val; nx_ic = 0; end
      if (load_osr) begin nx_osr = load_val; nx_oc = 0; end
    end else if (do_push) begin
      t = dec(int'(isr_thresh));
      if (!(if_flag && m_ic < t)) begin
        if (rx_full && block) e_stall = 1;
        else begin
          if (rx_full) e_ovf = 1;
          else begin e_push = 1; e_rx = m_isr; end
          nx_isr = 0; nx_ic = 0;
        end
      end
    end else if (do_pull) begin
      t = dec(int'(osr_thresh));
      if (!(if_flag && m_oc < t)) begin
        if (tx_empty && block) e_stall = 1;
        else if (tx_empty) begin nx_osr = x_in; nx_oc = 0; end
        else begin e_pull = 1; nx_osr = tx_data; nx_oc = 0; end
      end
    end else if (do_in) begin
      n = dec(int'(in_count));
      t = dec(int'(isr_thresh));
      lo = 64'(in_data) % p2(n);
      if (in_dir == 0) v = (64'(m_isr) * p2(n) + lo) % p2(32);
      else v = 64'(m_isr) / p2(n) + lo * p2(32 - n);
      if (auto_push && (m_ic + n >= t)) begin
        if (rx_full) e_stall = 1;
        else begin e_push = 1; e_rx = 32'(v); nx_isr = 0; nx_ic = 0; end
      end else begin
        nx_isr = 32'(v);
        nx_ic = (m_ic + n > 32) ? 32 : m_ic + n;
      end
    end else if (do_out) begin
      n = dec(int'(out_count));
      t = dec(int'(osr_thresh));
      if (auto_pull && m_oc >= t) begin
        e_stall = 1;
        if (!tx_empty) begin e_pull = 1; nx_osr = tx_data; nx_oc = 0; end
      end else begin
        e_out_v = 1;
        if (out_dir == 0) begin
          e_out = 32'(64'(m_osr) / p2(32 - n));
          nx_osr = 32'((64'(m_osr) * p2(n)) % p2(32));
        end else begin
          e_out = 32'(64'(m_osr) % p2(n));
          nx_osr = 32'(64'(m_osr) / p2(n));
        end
        nx_oc = (m_oc + n > 32) ? 32 : m_oc + n;
      end
    end
    if (!(penable && reset)) begin e_push = 0; e_pull = 0; e_ovf = 0; end
  endtask

  task automatic model_commit();
    if (!reset) begin
      m_isr = 0; m_osr = 0; m_ic = 0; m_oc = 32;
    end else if (penable) begin
      m_isr = nx_isr; m_osr = nx_osr; m_ic = nx_ic; m_oc = nx_oc;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (osr_count !== 6'd32) begin fails++; $display("[TB] FAIL reset_osr_count: got %0d want 32", osr_count); end
    tests++; if (isr_count !== 6'd0) begin fails++; $display("[TB] FAIL reset_isr_count: got %0d want 0", isr_count); end
    tests++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    tests++; if ({rx_push, tx_pull, rx_overflow} !== 3'b000) begin fails++; $display("[TB] FAIL reset_strobes: got %b want 000", {rx_push, tx_pull, rx_overflow}); end
    @(posedge clk); #1;
    tests++; if ({isr_count, osr_count} !== {6'd0, 6'd32}) begin fails++; $display("[TB] FAIL idle_tick_counts: got %0d/%0d want 0/32", isr_count, osr_count); end
  endtask

  task automatic test_autopush();
    do_reset();
    auto_push = 1; isr_thresh = 8; in_dir = 0;
    do_in = 1; in_count = 4; in_data = 32'hA;
    @(posedge clk); #1;
    tests++; if (isr_count !== 6'd4) begin fails++; $display("[TB] FAIL in4_count: got %0d want 4", isr_count); end
    in_data = 32'h5; rx_full = 1;
    @(negedge clk);
    tests++; if ({stall, rx_push} !== 2'b10) begin fails++; $display("[TB] FAIL in_full_stall: stall/rx_push %b want 10", {stall, rx_push}); end
    @(posedge clk); #1;
    tests++; if (isr_count !== 6'd4) begin fails++; $display("[TB] FAIL in_full_hold: got %0d want 4", isr_count); end
    rx_full = 0;
    @(negedge clk);
    tests++; if ({stall, rx_push} !== 2'b01) begin fails++; $display("[TB] FAIL in_autopush: stall/rx_push %b want 01", {stall, rx_push}); end
    tests++; if (rx_data !== 32'h000000A5) begin fails++; $display("[TB] FAIL in_autopush_data: got %h want 000000a5", rx_data); end
    @(posedge clk); #1;
    tests++; if (isr_count !== 6'd0) begin fails++; $display("[TB] FAIL in_autopush_clear: got %0d want 0", isr_count); end
  endtask

  task automatic test_autopull();
    do_reset();
    auto_pull = 1; osr_thresh = 0; out_dir = 0;
    do_out = 1; out_count = 8; tx_empty = 1;
    @(negedge clk);
    tests++; if ({stall, tx_pull} !== 2'b10) begin fails++; $display("[TB] FAIL out_empty_stall: stall/tx_pull %b want 10", {stall, tx_pull}); end
    @(posedge clk); #1;
    tx_empty = 0; tx_data = 32'h12345678;
    @(negedge clk);
    tests++; if ({stall, tx_pull} !== 2'b11) begin fails++; $display("[TB] FAIL out_refill: stall/tx_pull %b want 11", {stall, tx_pull}); end
    @(posedge clk); #1;
    tests++; if (osr_count !== 6'd0) begin fails++; $display("[TB] FAIL out_refill_count: got %0d want 0", osr_count); end
    tx_empty = 1;
    @(negedge clk);
    tests++; if ({stall, tx_pull} !== 2'b00) begin fails++; $display("[TB] FAIL out_after_refill: stall/tx_pull %b want 00", {stall, tx_pull}); end
    tests++; if (out_data !== 32'h12) begin fails++; $display("[TB] FAIL out_left8: got %h want 00000012", out_data); end
    @(posedge clk); #1;
    tests++; if (osr_count !== 6'd8) begin fails++; $display("[TB] FAIL out_left8_count: got %0d want 8", osr_count); end
  endtask

  task automatic test_right_shift();
    do_reset();
    load_osr = 1; load_val = 32'hCAFEF00D;
    @(posedge clk); #1;
    clear_cmd(); do_out = 1; out_dir = 1; out_count = 0;
    @(negedge clk);
    tests++; if (out_data !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL out_right32: got %h want cafef00d", out_data); end
    @(posedge clk); #1;
    tests++; if (osr_count !== 6'd32) begin fails++; $display("[TB] FAIL out_right32_count: got %0d want 32", osr_count); end
    clear_cmd(); load_osr = 1;
    @(posedge clk); #1;
    clear_cmd(); do_out = 1; out_count = 4;
    @(negedge clk);
    tests++; if (out_data !== 32'hD) begin fails++; $display("[TB] FAIL out_right4: got %h want 0000000d", out_data); end
    @(posedge clk); #1;
    tests++; if (osr_count !== 6'd4) begin fails++; $display("[TB] FAIL out_right4_count: got %0d want 4", osr_count); end
  endtask

  task automatic test_pull();
    do_reset();
    do_pull = 1; tx_empty = 1; x_in = 32'hDEADBEEF;
    @(negedge clk);
    tests++; if ({stall, tx_pull} !== 2'b00) begin fails++; $display("[TB] FAIL pull_x: stall/tx_pull %b want 00", {stall, tx_pull}); end
    @(posedge clk); #1;
    tests++; if (osr_count !== 6'd0) begin fails++; $display("[TB] FAIL pull_x_count: got %0d want 0", osr_count); end
    clear_cmd(); do_out = 1; out_dir = 1; out_count = 4;
    @(negedge clk);
    tests++; if (out_data !== 32'hF) begin fails++; $display("[TB] FAIL pull_x_nibble: got %h want 0000000f", out_data); end
    @(posedge clk); #1;
    clear_cmd(); do_pull = 1; if_flag = 1; tx_empty = 0; tx_data = 32'h11111111;
    @(negedge clk);
    tests++; if ({stall, tx_pull} !== 2'b00) begin fails++; $display("[TB] FAIL pull_ifempty_noop: stall/tx_pull %b want 00", {stall, tx_pull}); end
    @(posedge clk); #1;
    tests++; if (osr_count !== 6'd4) begin fails++; $display("[TB] FAIL pull_ifempty_count: got %0d want 4", osr_count); end
    clear_cmd(); tx_empty = 1; do_out = 1; out_count = 0;
    @(negedge clk);
    tests++; if (out_data !== 32'h0DEADBEE) begin fails++; $display("[TB] FAIL pull_ifempty_osr: got %h want 0deadbee", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_push_block();
    do_reset();
    load_isr = 1; load_val = 32'h1234;
    @(posedge clk); #1;
    clear_cmd(); do_push = 1; block = 1; rx_full = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if ({stall, rx_push} !== 2'b10) begin fails++; $display("[TB] FAIL push_block_stall%0d: stall/rx_push %b want 10", i, {stall, rx_push}); end
      @(posedge clk); #1;
    end
    reset = 0;
    @(negedge clk);
    tests++; if (rx_push !== 1'b0) begin fails++; $display("[TB] FAIL push_reset_strobe: got %b want 0", rx_push); end
    @(posedge clk); #1;
    reset = 1; rx_full = 0;
    @(negedge clk);
    tests++; if ({rx_push, rx_data} !== {1'b1, 32'h0}) begin fails++; $display("[TB] FAIL push_after_reset: rx_push %b data %h want 1 00000000", rx_push, rx_data); end
    @(posedge clk); #1;
    clear_cmd(); load_isr = 1; load_val = 32'hBEEF;
    @(posedge clk); #1;
    clear_cmd(); do_push = 1; block = 1; rx_full = 1;
    repeat (2) begin @(posedge clk); #1; end
    rx_full = 0;
    @(negedge clk);
    tests++; if ({stall, rx_push, rx_data} !== {2'b01, 32'hBEEF}) begin fails++; $display("[TB] FAIL push_release: stall/rx_push %b data %h want 01 0000beef", {stall, rx_push}, rx_data); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if ({rx_push, rx_data} !== {1'b1, 32'h0}) begin fails++; $display("[TB] FAIL push_cleared: rx_push %b data %h want 1 00000000", rx_push, rx_data); end
    @(posedge clk); #1;
    clear_cmd(); load_isr = 1; load_val = 32'h77;
    @(posedge clk); #1;
    clear_cmd(); do_push = 1; rx_full = 1;
    @(negedge clk);
    tests++; if ({rx_overflow, rx_push, stall} !== 3'b100) begin fails++; $display("[TB] FAIL push_overflow: ovf/push/stall %b want 100", {rx_overflow, rx_push, stall}); end
    @(posedge clk); #1;
    rx_full = 0;
    @(negedge clk);
    tests++; if (rx_data !== 32'h0) begin fails++; $display("[TB] FAIL push_overflow_drop: got %h want 00000000", rx_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_penable();
    do_reset();
    load_isr = 1; load_val = 32'h5A5A;
    @(posedge clk); #1;
    clear_cmd(); do_push = 1; penable = 0;
    @(negedge clk);
    tests++; if ({rx_push, stall} !== 2'b00) begin fails++; $display("[TB] FAIL penable_low_strobe: rx_push/stall %b want 00", {rx_push, stall}); end
    @(posedge clk); #1;
    block = 1; rx_full = 1;
    @(negedge clk);
    tests++; if (stall !== 1'b1) begin fails++; $display("[TB] FAIL penable_low_stall: got %b want 1", stall); end
    @(posedge clk); #1;
    penable = 1; rx_full = 0;
    @(negedge clk);
    tests++; if ({rx_push, rx_data} !== {1'b1, 32'h5A5A}) begin fails++; $display("[TB] FAIL penable_hold: rx_push %b data %h want 1 00005a5a", rx_push, rx_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    do_reset();
    m_isr = 0; m_osr = 0; m_ic = 0; m_oc = 32;
    for (int i = 0; i < 800; i++) begin
      penable = ($urandom_range(0, 4) != 0);
      reset = ($urandom_range(0, 39) != 0);
      in_dir = 1'($urandom); out_dir = 1'($urandom);
      auto_push = 1'($urandom); auto_pull = 1'($urandom);
      isr_thresh = 5'($urandom); osr_thresh = 5'($urandom);
      in_count = 5'($urandom); out_count = 5'($urandom);
      in_data = $urandom; x_in = $urandom; load_val = $urandom; tx_data = $urandom;
      do_in = ($urandom_range(0, 2) == 0); do_out = ($urandom_range(0, 2) == 0);
      do_push = ($urandom_range(0, 4) == 0); do_pull = ($urandom_range(0, 4) == 0);
      load_isr = ($urandom_range(0, 11) == 0); load_osr = ($urandom_range(0, 11) == 0);
      if_flag = 1'($urandom); block = 1'($urandom);
      rx_full = ($urandom_range(0, 2) == 0); tx_empty = ($urandom_range(0, 2) == 0);
      model_eval();
      @(negedge clk);
      if (reset) begin
        tests++; if (stall !== e_stall) begin fails++; $display("[TB] FAIL rnd%0d_stall: got %b want %b", i, stall, e_stall); end
      end
      tests++; if ({rx_push, tx_pull, rx_overflow} !== {e_push, e_pull, e_ovf}) begin fails++; $display("[TB] FAIL rnd%0d_strobes: got %b want %b", i, {rx_push, tx_pull, rx_overflow}, {e_push, e_pull, e_ovf}); end
      if (e_push) begin
        tests++; if (rx_data !== e_rx) begin fails++; $display("[TB] FAIL rnd%0d_rx_data: got %h want %h", i, rx_data, e_rx); end
      end
      if (e_out_v) begin
        tests++; if (out_data !== e_out) begin fails++; $display("[TB] FAIL rnd%0d_out_data: got %h want %h", i, out_data, e_out); end
      end
      @(posedge clk); #1;
      model_commit();
      tests++; if ({isr_count, osr_count} !== {6'(m_ic), 6'(m_oc)}) begin fails++; $display("[TB] FAIL rnd%0d_counts: got %0d/%0d want %0d/%0d", i, isr_count, osr_count, m_ic, m_oc); end
    end
  endtask

  initial begin
    defaults();
    reset = 0;
    test_reset();
    test_autopush();
    test_autopull();
    test_right_shift();
    test_pull();
    test_push_block();
    test_penable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
